// File: rtl/rr_mux_arb.sv
// N-channel round-robin arbitrating mux with a one-entry registered output stage.
// Define RR_MUX_LOCK_EN to add in_last and hold the grant on one channel until end of packet.

module rr_mux_lane #(
    parameter int W = 8
) (
    input  logic         i_sel,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);
    assign o_data = i_data & {W{i_sel}};
endmodule

module rr_mux_arb #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [N-1:0]   i_in_valid,
    output logic [N-1:0]   o_in_ready,
    input  logic [N*W-1:0] i_in_data,
`ifdef RR_MUX_LOCK_EN
    input  logic [N-1:0]   i_in_last,
`endif
    output logic           o_out_valid,
    input  logic           i_out_ready,
    output logic [W-1:0]   o_out_data,
    output logic [SW-1:0]  o_out_ch,
    output logic [N-1:0]   o_grant
);
    logic [SW-1:0]         r_ptr;
    logic [SW-1:0]         r_ch;
    logic                  r_vld;
    logic [W-1:0]          r_data;

    logic                  w_load;
    logic                  w_found;
    logic                  w_xfer;
    logic [SW-1:0]         w_win;
    logic [SW-1:0]         w_idx;
    logic [N-1:0]          w_grant;
    logic [N-1:0][W-1:0]   w_lane;
    logic [N-1:0][W-1:0]   w_masked;
    logic [W-1:0]          w_sel;

`ifdef RR_MUX_LOCK_EN
    logic                  r_lock;
`endif

    assign w_lane = i_in_data;
    assign w_load = !r_vld | i_out_ready;

    // Search ptr+1, ptr+2, ... with explicit wrap so non-power-of-2 N works.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = r_ptr;
        for (int i = 0; i < N; i++) begin
            w_idx = (w_idx == SW'(N-1)) ? '0 : w_idx + 1'b1;
            if (!w_found && i_in_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
`ifdef RR_MUX_LOCK_EN
        // ptr always holds the locked channel since it tracks the last winner.
        if (r_lock) begin
            w_found = i_in_valid[r_ptr];
            w_win   = r_ptr;
        end
`endif
    end

    always_comb begin
        w_grant = '0;
        for (int k = 0; k < N; k++)
            w_grant[k] = w_found && (w_win == SW'(k));
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        rr_mux_lane #(.W(W)) u_lane (
            .i_sel  (w_grant[g]),
            .i_data (w_lane[g]),
            .o_data (w_masked[g])
        );
    end

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < N; k++)
            w_sel = w_sel | w_masked[k];
    end

    assign w_xfer = w_found & w_load;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_ch   <= '0;
            r_ptr  <= SW'(N-1);
        end else begin
            if (w_load)
                r_vld <= w_found;
            if (w_xfer) begin
                r_data <= w_sel;
                r_ch   <= w_win;
                r_ptr  <= w_win;
            end
        end
    end

`ifdef RR_MUX_LOCK_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_lock <= 1'b0;
        else if (w_xfer)
            r_lock <= !i_in_last[w_win];
    end
`endif

    assign o_grant     = w_grant;
    assign o_in_ready  = w_grant & {N{w_load}};
    assign o_out_valid = r_vld;
    assign o_out_data  = r_data;
    assign o_out_ch    = r_ch;
endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb (N=4, W=8); lock scenario runs when RR_MUX_LOCK_EN is defined.

module tb_rr_mux_arb;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
`ifdef RR_MUX_LOCK_EN
    logic [N-1:0]   in_last;
`endif
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic [N-1:0]   grant;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_d [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    int         exp_c [5] = '{0, 1, 2, 3, 0};

    rr_mux_arb #(.N(N), .W(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
`ifdef RR_MUX_LOCK_EN
        .i_in_last   (in_last),
`endif
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_ch    (out_ch),
        .o_grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int k, input logic [7:0] v);
        in_data[k*W +: W] = v;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef RR_MUX_LOCK_EN
        in_last   = '0;
`endif
        #3;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data",  32'(out_data),  32'h0);
        chk("rst_ch",    32'(out_ch),    32'h0);
        chk("rst_grant", 32'(grant),     32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // All four request: strict rotation starting at channel 0.
        set_lane(0, 8'h10); set_lane(1, 8'h21); set_lane(2, 8'h32); set_lane(3, 8'h43);
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("t1_grant0", 32'(grant),    32'h1);
        chk("t1_rdy0",   32'(in_ready), 32'h1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t1_valid", 32'(out_valid), 32'h1);
            chk("t1_data",  32'(out_data),  32'(exp_d[i]));
            chk("t1_ch",    32'(out_ch),    32'(exp_c[i]));
            chk("t1_grant", 32'(grant),     32'(1) << ((exp_c[i] + 1) % 4));
        end

        // No requests: output drains, data/ch hold.
        in_valid = '0;
        #1;
        chk("t6_grant", 32'(grant),    32'h0);
        chk("t6_rdy",   32'(in_ready), 32'h0);
        cyc();
        chk("t6_valid", 32'(out_valid), 32'h0);
        chk("t6_data",  32'(out_data),  32'h10);
        chk("t6_ch",    32'(out_ch),    32'h0);

        // Single requester on channel 2: back-to-back beats.
        set_lane(2, 8'hA5);
        in_valid = 4'b0100;
        #1;
        chk("t2_rdy0", 32'(in_ready), 32'h4);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t2_valid", 32'(out_valid), 32'h1);
            chk("t2_data",  32'(out_data),  32'hA5);
            chk("t2_ch",    32'(out_ch),    32'h2);
            chk("t2_rdy",   32'(in_ready),  32'h4);
        end
        in_valid = '0;
        cyc();
        chk("t2_drain", 32'(out_valid), 32'h0);

        // Backpressure: beat from ch1 held while ch3 waits.
        set_lane(2, 8'h32);
        set_lane(1, 8'h5A);
        in_valid = 4'b0010;
        cyc();
        chk("t3_data1", 32'(out_data), 32'h5A);
        chk("t3_ch1",   32'(out_ch),   32'h1);
        in_valid  = 4'b1000;
        out_ready = 1'b0;
        #1;
        chk("t3_grant", 32'(grant),    32'h8);
        chk("t3_rdy0",  32'(in_ready), 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t3_hvalid", 32'(out_valid), 32'h1);
            chk("t3_hdata",  32'(out_data),  32'h5A);
            chk("t3_hch",    32'(out_ch),    32'h1);
            chk("t3_hrdy",   32'(in_ready),  32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("t3_rdy1", 32'(in_ready), 32'h8);
        cyc();
        chk("t3_data3", 32'(out_data),  32'h43);
        chk("t3_ch3",   32'(out_ch),    32'h3);
        chk("t3_valid", 32'(out_valid), 32'h1);
        in_valid = '0;
        cyc();
        chk("t3_drain", 32'(out_valid), 32'h0);

        // Asynchronous reset while a beat is held.
        set_lane(1, 8'h21);
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        cyc();
        chk("t4_pre_valid", 32'(out_valid), 32'h1);
        chk("t4_pre_data",  32'(out_data),  32'h10);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_rst_valid", 32'(out_valid), 32'h0);
        chk("t4_rst_data",  32'(out_data),  32'h0);
        chk("t4_rst_ch",    32'(out_ch),    32'h0);
        chk("t4_rst_grant", 32'(grant),     32'h1);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("t4_first_data", 32'(out_data),  32'h10);
        chk("t4_first_ch",   32'(out_ch),    32'h0);
        chk("t4_first_vld",  32'(out_valid), 32'h1);

`ifdef RR_MUX_LOCK_EN
        // Packet lock: three ch1 beats stay contiguous, then ch2 before ch0.
        in_valid = '0;
        cyc();
        chk("t5_idle", 32'(out_valid), 32'h0);
        set_lane(1, 8'h61);
        in_last  = 4'b0000;
        in_valid = 4'b0111;
        #1;
        chk("t5_g0", 32'(grant), 32'h2);
        cyc();
        chk("t5_d0", 32'(out_data), 32'h61);
        chk("t5_c0", 32'(out_ch),   32'h1);
        set_lane(1, 8'h62);
        #1;
        chk("t5_g1", 32'(grant), 32'h2);
        cyc();
        chk("t5_d1", 32'(out_data), 32'h62);
        chk("t5_c1", 32'(out_ch),   32'h1);
        set_lane(1, 8'h63);
        in_last = 4'b0010;
        #1;
        chk("t5_g2", 32'(grant), 32'h2);
        cyc();
        chk("t5_d2", 32'(out_data), 32'h63);
        chk("t5_c2", 32'(out_ch),   32'h1);
        chk("t5_g3", 32'(grant),    32'h4);
        cyc();
        chk("t5_d3", 32'(out_data), 32'h32);
        chk("t5_c3", 32'(out_ch),   32'h2);
        chk("t5_g4", 32'(grant),    32'h1);
        cyc();
        chk("t5_d4", 32'(out_data), 32'h10);
        chk("t5_c4", 32'(out_ch),   32'h0);
`endif

        in_valid = '0;
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rr_mux_arb.md
# rr_mux_arb

Parametrised N-channel, W-bit round-robin arbitrating multiplexer with a valid/ready handshake on every input and on the output. A one-hot grant decoder drives an AND-OR select, the wired-OR equivalent of decoder-plus-tristate selection. A one-entry output register provides one-cycle latency at full throughput. The block sits wherever several producers share one downstream consumer, replacing the static 4:1 select with arbitrated, flow-controlled selection.

## Interface
- N, 4, number of input channels (2..16)
- W, 8, data width per channel
- SW, $clog2(N), derived select width; not overridden
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  N  per-channel request; bit k belongs to channel k
- in_ready  output  N  per-channel accept; at most one bit high per cycle
- in_data  input  N*W  channel k data on bits [k*W +: W]
- in_last  input  N  end-of-packet marker; present only with RR_MUX_LOCK_EN
- out_valid  output  1  output register holds a beat
- out_ready  input  1  consumer accepts the beat
- out_data  output  W  registered selected data
- out_ch  output  SW  index of the channel that supplied out_data
- grant  output  N  one-hot combinational grant for the current cycle; zero when no request

## Operation
- load_en = !out_valid | out_ready. The output register is empty or being drained this cycle.
- Arbiter state ptr (SW bits) is the last granted channel. Search order is ptr+1, ptr+2, … wrapping modulo N. The first requesting channel wins.
- grant[k] = 1 for the winner when any in_valid is set; otherwise grant = 0. The grant is computed regardless of load_en.
- in_ready[k] = grant[k] & load_en. Transfer on channel k = in_valid[k] & in_ready[k].
- On transfer:
  - out_data <= in_data of the granted channel, via AND-OR of the grant-masked lanes.
  - out_ch <= winner index.
  - out_valid <= 1.
  - ptr <= winner index.
- With load_en and no request: out_valid <= 0. out_data and out_ch hold their previous values.
- Without load_en (out_valid & !out_ready): all registers hold, in_ready = 0, ptr unchanged.
- A channel that keeps requesting waits at most N-1 grants.
- N is not required to be a power of 2. Wrap uses explicit compare with N-1, never natural overflow.

## Timing
- Reset, asynchronous and taking effect immediately:
  - out_valid = 0, out_data = 0, out_ch = 0.
  - ptr = N-1, so channel 0 has first priority.
  - Lock state cleared.
- Reset mid-transfer discards the held beat. No output is produced for it.
- Latency is 1 cycle: a beat accepted at edge t is visible on out_valid/out_data after edge t.
- Throughput is 1 beat per cycle while out_ready = 1, including back-to-back beats from the same channel when it is the only requester.
- in_ready depends combinationally on out_ready and in_valid. Producers must not make in_valid depend on in_ready.
- Once asserted, in_valid and in_data must be held until accepted. The block does not enforce this.
- out_valid/out_data are stable while out_valid & !out_ready.
- Simultaneous drain and load in one cycle is legal and yields no bubble.

## Configuration
- RR_MUX_LOCK_EN defined:
  - Adds the in_last port and a lock flag.
  - After a transfer with in_last[k] = 0, the lock is set and the grant is forced to channel k. Other channels' requests are ignored.
  - While locked, grant[k] = in_valid[k] and grant = 0 otherwise.
  - The lock clears on a transfer from channel k with in_last[k] = 1. Normal round-robin resumes from ptr = k.
- RR_MUX_LOCK_EN undefined:
  - No in_last port and no lock flag.
  - Arbitration happens on every beat.

## Test plan
- Reset, then in_valid = 4'b1111 with in_data lanes 0x10/0x21/0x32/0x43 and out_ready = 1 -> outputs 0x10, 0x21, 0x32, 0x43, 0x10… on consecutive cycles, out_ch = 0, 1, 2, 3, 0.
- Only channel 2 valid, data 0xA5, for 3 cycles with out_ready = 1 -> three beats of 0xA5, out_ch = 2, no bubbles, in_ready = 4'b0100 each cycle.
- Fill one beat (ch 1, 0x5A), then out_ready = 0 for 4 cycles with ch 3 valid -> out_data stays 0x5A, in_ready = 0. Raise out_ready -> 0x5A accepted and ch 3 beat appears the next cycle.
- rst_n pulsed low while out_valid = 1 -> out_valid = 0 and out_data = 0 asynchronously; the first grant after release goes to channel 0 when all request.
- With RR_MUX_LOCK_EN, ch 1 sends 3 beats with last = 0, 0, 1 while ch 0 and ch 2 request -> the three ch 1 beats are contiguous, then ch 2 is granted before ch 0.
- No requests and out_ready = 1 after a beat -> out_valid falls to 0 the next cycle and grant = 0.
